led_scene_sequencer: RTL and testbench

Scene sequencer for the user RGB LED PWM bank. It holds a small table of RGB duty scenes and plays them in order, each with a per-scene hold time and an optional linear crossfade. Its three 0–100 % duty outputs feed the existing per-channel PWM controllers in place of the rainbow generator. It runs on the 100 MHz system clock and advances on the shared 10 kHz clock enable.

---
 rtl/led_scene_pkg.sv | 28 ++
 rtl/led_scene_sequencer_if.sv | 31 +++
 rtl/led_scene_fader.sv | 32 +++
 rtl/led_scene_sequencer.sv | 151 +++++++++++++++
 tb/tb_led_scene_sequencer.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/led_scene_pkg.sv
// rtl/led_scene_pkg.sv - shared types, entry layout and duty clamp for the LED scene sequencer
package led_scene_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FADE = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  localparam logic [6:0] C_DUTY_MAX = 7'd100;

  // Entry packing: {hold, r, g, b} with 7-bit colour fields at the bottom
  localparam int C_COLOR_W  = 7;
  localparam int C_B_LSB    = 0;
  localparam int C_G_LSB    = 7;
  localparam int C_R_LSB    = 14;
  localparam int C_HOLD_LSB = 21;

  function automatic int entry_w(input int hold_w);
    return hold_w + C_HOLD_LSB;
  endfunction

  function automatic logic [6:0] clamp_duty(input logic [6:0] v);
    return (v > C_DUTY_MAX) ? C_DUTY_MAX : v;
  endfunction

endpackage

// File: rtl/led_scene_sequencer_if.sv
// rtl/led_scene_sequencer_if.sv - host-side control/table bus of the LED scene sequencer
interface led_scene_sequencer_if
  import led_scene_pkg::*;
#(
  parameter int P_AW     = 3,
  parameter int P_HOLD_W = 16
);
  logic                          I_WR_EN;
  logic [P_AW-1:0]               I_WR_ADDR;
  logic [entry_w(P_HOLD_W)-1:0]  I_WR_DATA;
  logic [P_AW-1:0]               I_LAST;
  logic                          I_LOOP;
  logic                          I_START;
  logic                          I_STOP;
  logic [6:0]                    O_DUTY_R;
  logic [6:0]                    O_DUTY_G;
  logic [6:0]                    O_DUTY_B;
  logic                          O_BUSY;
  logic [P_AW-1:0]               O_INDEX;
  logic                          O_DONE;

  modport master (
    output I_WR_EN, I_WR_ADDR, I_WR_DATA, I_LAST, I_LOOP, I_START, I_STOP,
    input  O_DUTY_R, O_DUTY_G, O_DUTY_B, O_BUSY, O_INDEX, O_DONE
  );

  modport slave (
    input  I_WR_EN, I_WR_ADDR, I_WR_DATA, I_LAST, I_LOOP, I_START, I_STOP,
    output O_DUTY_R, O_DUTY_G, O_DUTY_B, O_BUSY, O_INDEX, O_DONE
  );
endinterface

// File: rtl/led_scene_fader.sv
// rtl/led_scene_fader.sv - one duty channel stepping one unit per enable toward its target
`ifdef LED_SCENE_FADE_EN
module led_scene_fader (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       step_i,
  input  logic [6:0] target_i,
  output logic [6:0] duty_o,
  output logic       at_target_o
);
  logic [6:0] duty_q, duty_d;

  assign at_target_o = (duty_q == target_i);
  assign duty_o      = duty_q;

  always_comb begin
    duty_d = duty_q;
    if (step_i && !at_target_o) begin
      duty_d = (duty_q < target_i) ? duty_q + 7'd1 : duty_q - 7'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      duty_q <= 7'd0;
    end else begin
      duty_q <= duty_d;
    end
  end
endmodule
`endif

// File: rtl/led_scene_sequencer.sv
// rtl/led_scene_sequencer.sv - plays a table of RGB duty scenes with hold times
// LED_SCENE_FADE_EN adds a linear per-tick crossfade; without it duties jump to target
module led_scene_sequencer
  import led_scene_pkg::*;
#(
  parameter int P_AW     = 3,
  parameter int P_HOLD_W = 16
) (
  input  logic                 I_CLK_100MHZ,
  input  logic                 I_RST,
  input  logic                 I_CE_10KHZ,
  led_scene_sequencer_if.slave bus
);
  localparam int C_ENTRY_W = entry_w(P_HOLD_W);
  localparam int C_DEPTH   = 2 ** P_AW;

  state_e                state_q, state_d;
  logic [P_AW-1:0]       index_q, index_d;
  logic [P_HOLD_W-1:0]   cnt_q, cnt_d, hold_q;
  logic                  done_q, done_d;
  logic [C_ENTRY_W-1:0]  table_q [C_DEPTH];
  logic [C_ENTRY_W-1:0]  rd_entry, wr_entry;
  logic [6:0]            duty_r, duty_g, duty_b;
  logic                  scene_end, seq_over;

  assign wr_entry = {bus.I_WR_DATA[C_HOLD_LSB +: P_HOLD_W],
                     clamp_duty(bus.I_WR_DATA[C_R_LSB +: C_COLOR_W]),
                     clamp_duty(bus.I_WR_DATA[C_G_LSB +: C_COLOR_W]),
                     clamp_duty(bus.I_WR_DATA[C_B_LSB +: C_COLOR_W])};
  assign rd_entry = table_q[index_q];

  always_ff @(posedge I_CLK_100MHZ) begin
    if (bus.I_WR_EN) table_q[bus.I_WR_ADDR] <= wr_entry;
  end

  // Read port is registered during LOAD, so a same-cycle write is seen only on the next load
  always_ff @(posedge I_CLK_100MHZ) begin
    if (state_q == S_LOAD) hold_q <= rd_entry[C_HOLD_LSB +: P_HOLD_W];
  end

`ifdef LED_SCENE_FADE_EN
  logic [6:0] tgt_r_q, tgt_g_q, tgt_b_q;
  logic [2:0] at_tgt;
  logic       step_en, fade_done;

  always_ff @(posedge I_CLK_100MHZ) begin
    if (state_q == S_LOAD) begin
      tgt_r_q <= rd_entry[C_R_LSB +: C_COLOR_W];
      tgt_g_q <= rd_entry[C_G_LSB +: C_COLOR_W];
      tgt_b_q <= rd_entry[C_B_LSB +: C_COLOR_W];
    end
  end

  assign step_en   = (state_q == S_FADE) && I_CE_10KHZ;
  assign fade_done = &at_tgt;

  led_scene_fader u_fade_r (.clk_i(I_CLK_100MHZ), .rst_i(I_RST), .clr_i(bus.I_STOP), .step_i(step_en),
                            .target_i(tgt_r_q), .duty_o(duty_r), .at_target_o(at_tgt[2]));
  led_scene_fader u_fade_g (.clk_i(I_CLK_100MHZ), .rst_i(I_RST), .clr_i(bus.I_STOP), .step_i(step_en),
                            .target_i(tgt_g_q), .duty_o(duty_g), .at_target_o(at_tgt[1]));
  led_scene_fader u_fade_b (.clk_i(I_CLK_100MHZ), .rst_i(I_RST), .clr_i(bus.I_STOP), .step_i(step_en),
                            .target_i(tgt_b_q), .duty_o(duty_b), .at_target_o(at_tgt[0]));
`else
  logic [6:0] duty_r_q, duty_g_q, duty_b_q;

  always_ff @(posedge I_CLK_100MHZ) begin
    if (I_RST || bus.I_STOP) begin
      duty_r_q <= 7'd0;
      duty_g_q <= 7'd0;
      duty_b_q <= 7'd0;
    end else if (state_q == S_LOAD) begin
      duty_r_q <= rd_entry[C_R_LSB +: C_COLOR_W];
      duty_g_q <= rd_entry[C_G_LSB +: C_COLOR_W];
      duty_b_q <= rd_entry[C_B_LSB +: C_COLOR_W];
    end
  end

  assign duty_r = duty_r_q;
  assign duty_g = duty_g_q;
  assign duty_b = duty_b_q;
`endif

  // Hold counts up from 0, so a scene ends on the tick where cnt equals the hold value
  assign scene_end = (state_q == S_HOLD) && I_CE_10KHZ && (cnt_q == hold_q);
  assign seq_over  = (index_q == bus.I_LAST) && !bus.I_LOOP;

  always_ff @(posedge I_CLK_100MHZ) begin
    if (I_RST) begin
      state_q <= S_IDLE;
      index_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.I_STOP) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (bus.I_START) state_d = S_LOAD;
`ifdef LED_SCENE_FADE_EN
        S_LOAD: state_d = S_FADE;
        S_FADE: if (fade_done) state_d = S_HOLD;
`else
        S_LOAD: state_d = S_HOLD;
        S_FADE: state_d = S_HOLD;
`endif
        S_HOLD: if (scene_end) state_d = seq_over ? S_IDLE : S_LOAD;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    index_d = index_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (bus.I_STOP) begin
      index_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (bus.I_START) index_d = '0;
        S_LOAD: cnt_d = '0;
        S_HOLD: begin
          if (scene_end) begin
            if (index_q != bus.I_LAST) index_d = index_q + P_AW'(1);
            else if (bus.I_LOOP)       index_d = '0;
            else                       done_d  = 1'b1;
          end else if (I_CE_10KHZ) begin
            cnt_d = cnt_q + P_HOLD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.O_DUTY_R = duty_r;
  assign bus.O_DUTY_G = duty_g;
  assign bus.O_DUTY_B = duty_b;
  assign bus.O_BUSY   = (state_q != S_IDLE);
  assign bus.O_INDEX  = index_q;
  assign bus.O_DONE   = done_q;
endmodule

// File: tb/tb_led_scene_sequencer.sv
// tb/tb_led_scene_sequencer.sv - directed plus randomized bench with a scene-level reference model
module tb_led_scene_sequencer;
  localparam int AW = 3;
  localparam int HW = 16;

  logic clk = 1'b0;
  logic rst;
  logic ce;
  int   total = 0;
  int   bad = 0;
  int   ce_div = 1;
  int   dut_dones = 0;
  int   mdl_dones = 0;

  // Reference: phase 0 idle, 1 load, 2 fade, 3 hold; hold measured as ticks remaining
  int m_tab_r[8], m_tab_g[8], m_tab_b[8], m_tab_h[8];
  int m_phase, m_idx, m_dr, m_dg, m_db, m_tr, m_tg, m_tb, m_hold, m_left, m_done;

  always #5 clk = ~clk;

  led_scene_sequencer_if #(.P_AW(AW), .P_HOLD_W(HW)) bus ();

  led_scene_sequencer #(.P_AW(AW), .P_HOLD_W(HW)) dut (
    .I_CLK_100MHZ(clk),
    .I_RST       (rst),
    .I_CE_10KHZ  (ce),
    .bus         (bus)
  );

  function automatic int toward(int cur, int tgt);
    if (cur < tgt) return cur + 1;
    if (cur > tgt) return cur - 1;
    return cur;
  endfunction

  function automatic int clampi(int v);
    return (v > 100) ? 100 : v;
  endfunction

  task automatic model_step();
    logic [36:0] d;
    m_done = 0;
    if (rst || bus.I_STOP) begin
      if (rst || m_phase != 0 || 1) begin
        m_phase = 0;
        m_idx   = 0;
        m_dr = 0; m_dg = 0; m_db = 0;
      end
    end else begin
      case (m_phase)
        0: if (bus.I_START) begin m_phase = 1; m_idx = 0; end
        1: begin
          m_tr = m_tab_r[m_idx]; m_tg = m_tab_g[m_idx]; m_tb = m_tab_b[m_idx];
          m_hold = m_tab_h[m_idx];
`ifdef LED_SCENE_FADE_EN
          m_phase = 2;
`else
          m_dr = m_tr; m_dg = m_tg; m_db = m_tb;
          m_left = m_hold + 1;
          m_phase = 3;
`endif
        end
        2: begin
          if (m_dr == m_tr && m_dg == m_tg && m_db == m_tb) begin
            m_left  = m_hold + 1;
            m_phase = 3;
          end else if (ce) begin
            m_dr = toward(m_dr, m_tr); m_dg = toward(m_dg, m_tg); m_db = toward(m_db, m_tb);
          end
        end
        default: begin
          if (ce) begin
            m_left--;
            if (m_left == 0) begin
              if (m_idx != int'(bus.I_LAST)) begin m_idx = (m_idx + 1) % 8; m_phase = 1; end
              else if (bus.I_LOOP)         begin m_idx = 0; m_phase = 1; end
              else                         begin m_done = 1; m_phase = 0; end
            end
          end
        end
      endcase
    end
    if (bus.I_WR_EN) begin
      d = bus.I_WR_DATA;
      m_tab_h[bus.I_WR_ADDR] = int'(d[36:21]);
      m_tab_r[bus.I_WR_ADDR] = clampi(int'(d[20:14]));
      m_tab_g[bus.I_WR_ADDR] = clampi(int'(d[13:7]));
      m_tab_b[bus.I_WR_ADDR] = clampi(int'(d[6:0]));
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    ce = ($urandom_range(1, ce_div) == 1);
    model_step();
    @(posedge clk);
    #1;
    chk("duty_r", 32'(bus.O_DUTY_R), m_dr);
    chk("duty_g", 32'(bus.O_DUTY_G), m_dg);
    chk("duty_b", 32'(bus.O_DUTY_B), m_db);
    chk("busy",   32'(bus.O_BUSY), (m_phase != 0) ? 1 : 0);
    chk("index",  32'(bus.O_INDEX), m_idx);
    chk("done",   32'(bus.O_DONE), m_done);
    if (bus.O_DONE === 1'b1) dut_dones++;
    if (m_done != 0) mdl_dones++;
  endtask

  task automatic wr(input int a, input int h, input int r, input int g, input int b);
    bus.I_WR_EN   = 1'b1;
    bus.I_WR_ADDR = a[2:0];
    bus.I_WR_DATA = {h[15:0], r[6:0], g[6:0], b[6:0]};
    cyc();
    bus.I_WR_EN   = 1'b0;
  endtask

  task automatic pulse_start();
    bus.I_START = 1'b1;
    cyc();
    bus.I_START = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.I_STOP = 1'b1;
    cyc();
    bus.I_STOP = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic run_until_idle(input int maxc, input string tag);
    int n = 0;
    while (m_phase != 0 && n < maxc) begin
      cyc();
      n++;
    end
    chk(tag, 32'(bus.O_BUSY), 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; ce = 1'b0;
    bus.I_WR_EN = 1'b0; bus.I_WR_ADDR = '0; bus.I_WR_DATA = '0;
    bus.I_LAST = '0; bus.I_LOOP = 1'b0; bus.I_START = 1'b0; bus.I_STOP = 1'b0;
    m_phase = 0; m_idx = 0; m_dr = 0; m_dg = 0; m_db = 0;
    m_tr = 0; m_tg = 0; m_tb = 0; m_hold = 0; m_left = 0; m_done = 0;

    run(2);
    for (int a = 0; a < 8; a++)
      wr(a, $urandom_range(0, 3), $urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127));
    rst = 1'b0;
    run(2);

    // Fade up: single scene R 0 -> 10, hold 5
    ce_div = 1;
    wr(0, 5, 10, 0, 0);
    bus.I_LAST = 3'd0; bus.I_LOOP = 1'b0;
    pulse_start();
    run_until_idle(200, "fadeup_idle");
    chk("fadeup_r_final", 32'(bus.O_DUTY_R), 10);
    chk("fadeup_done_once", dut_dones, 1);

    // Loop and wrap over three primaries
    wr(0, 0, 100, 0, 0);
    wr(1, 0, 0, 100, 0);
    wr(2, 0, 0, 0, 100);
    bus.I_LAST = 3'd2; bus.I_LOOP = 1'b1;
    pulse_start();
    run(800);
    chk("loop_no_done", dut_dones, 1);
    pulse_stop();

    // Clamp: over-range colour fields saturate at 100
    wr(3, 1, 127, 120, 5);
    bus.I_LAST = 3'd3; bus.I_LOOP = 1'b0;
    pulse_start();
    run_until_idle(3000, "clamp_idle");
    chk("clamp_r", 32'(bus.O_DUTY_R), 100);
    chk("clamp_g", 32'(bus.O_DUTY_G), 100);

    // Stop priority and stop mid-play
    bus.I_START = 1'b1; bus.I_STOP = 1'b1;
    cyc();
    bus.I_START = 1'b0; bus.I_STOP = 1'b0;
    chk("stop_wins_busy", 32'(bus.O_BUSY), 0);
    pulse_start();
    run(5);
    pulse_stop();
    chk("stop_duty_r", 32'(bus.O_DUTY_R), 0);
    chk("stop_index", 32'(bus.O_INDEX), 0);

    // Reset during HOLD, then replay from the surviving table
    pulse_start();
    n = 0;
    while (m_phase != 3 && n < 2000) begin cyc(); n++; end
    chk("reach_hold_busy", 32'(bus.O_BUSY), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_busy", 32'(bus.O_BUSY), 0);
    chk("rst_duty_g", 32'(bus.O_DUTY_G), 0);
    pulse_start();
    run_until_idle(3000, "replay_idle");

    // Randomized play with live table writes, I_LAST/I_LOOP changes, stops and starts
    for (int k = 0; k < 6; k++) begin
      ce_div = $urandom_range(1, 3);
      bus.I_LAST = 3'($urandom_range(0, 7));
      bus.I_LOOP = 1'($urandom_range(0, 1));
      pulse_start();
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, 5) == 0) begin
          bus.I_WR_EN   = 1'b1;
          bus.I_WR_ADDR = 3'($urandom_range(0, 7));
          bus.I_WR_DATA = {16'($urandom_range(0, 3)), 7'($urandom_range(0, 127)),
                           7'($urandom_range(0, 127)), 7'($urandom_range(0, 127))};
        end
        if ($urandom_range(0, 99) == 0)  bus.I_LOOP = ~bus.I_LOOP;
        if ($urandom_range(0, 149) == 0) bus.I_LAST = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 299) == 0) bus.I_STOP = 1'b1;
        if ($urandom_range(0, 59) == 0)  bus.I_START = 1'b1;
        cyc();
        bus.I_WR_EN = 1'b0; bus.I_STOP = 1'b0; bus.I_START = 1'b0;
      end
    end
    pulse_stop();

    chk("done_count", dut_dones, mdl_dones);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
